cic_decimator: RTL and testbench



---
 rtl/cic_decimator_pkg.sv | 32 +++
 rtl/cic_decimator_if.sv | 16 +
 rtl/cic_decimator_comb_stage.sv | 30 +++
 rtl/cic_decimator.sv | 96 +++++++++
 tb/tb_cic_decimator.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_decimator_pkg.sv
// Shared definitions for the CIC decimator.
//   clog2      : constant ceil(log2(v)), used to size counters and accumulators
//   acc_width  : internal accumulator width IN_W + N*clog2(R*M)
//   acc_t      : signed accumulator type for the default configuration
package cic_decimator_pkg;

    localparam int N_STAGES  = 4;
    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 32;
    localparam int R_DEF     = 2;
    localparam int M_DEF     = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Bit growth of an N-stage CIC is N*log2(R*M); sizing the accumulators
    // this way makes wrap-around in the integrators harmless.
    function automatic int acc_width(input int in_w, input int n, input int r, input int m);
        return in_w + n * clog2(r * m);
    endfunction

    localparam int ACC_W_DEF = acc_width(IN_W_DEF, N_STAGES, R_DEF, M_DEF);

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream bundle for the CIC decimator.
//   d_in/in_valid   : high-rate input samples (source -> decimator)
//   d_out/out_valid : decimated output samples, one-cycle pulses (decimator -> sink)
// master = sample source / sink side, slave = decimator side.
interface cic_decimator_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
);
    logic signed [IN_W-1:0]  d_in;
    logic                    in_valid;
    logic signed [OUT_W-1:0] d_out;
    logic                    out_valid;

    modport master (output d_in, in_valid, input  d_out, out_valid);
    modport slave  (input  d_in, in_valid, output d_out, out_valid);
endinterface

// File: rtl/cic_decimator_comb_stage.sv
// One low-rate comb section: o_y = i_x - i_x delayed by M enabled samples.
//   clk, rst : clock, asynchronous active-low clear of the delay line
//   i_en     : advance the delay line (decimated sample strobe)
//   i_x      : comb input (previous stage output)
//   o_y      : comb output, combinational from i_x
module cic_comb_stage #(
    parameter int M = 2,
    parameter int W = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic signed [W-1:0] i_x,
    output logic signed [W-1:0] o_y
);

    logic signed [W-1:0] r_dly [M];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) r_dly[i] <= '0;
        end else if (i_en) begin
            r_dly[0] <= i_x;
            for (int i = 1; i < M; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign o_y = i_x - r_dly[M-1];

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator (decimation R, differential delay M).
//   clk  : system clock
//   rst  : asynchronous active-low reset, clears all filter state
//   bus  : slave side of the sample stream
//          d_in/in_valid   - full-rate signed input, may be valid every cycle
//          d_out/out_valid - decimated output, out_valid pulses 2 cycles after
//                            the R-th valid input; d_out holds between pulses
// Integrators run at the input rate, combs at the decimated rate. Output is
// the top OUT_W bits of the last comb (truncation), unity DC gain when R*M is
// a power of two.
module cic_decimator
    import cic_decimator_pkg::*;
#(
    parameter int R     = 2,
    parameter int M     = 2,
    parameter int N     = N_STAGES,
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    cic_decimator_if.slave bus
);

    localparam int ACC_W = acc_width(IN_W, N, R, M);
    localparam int CNT_W = clog2(R);

    logic signed [ACC_W-1:0] w_din_ext;
    logic signed [ACC_W-1:0] r_integ [N];
    logic [CNT_W-1:0]        r_dec_cnt;
    logic                    w_dec_hit;
    logic                    r_s_valid;
    logic signed [ACC_W-1:0] w_c [N+1];
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_out_valid;

    assign w_din_ext = {{(ACC_W-IN_W){bus.d_in[IN_W-1]}}, bus.d_in};

    // Pipelined integrators: each stage adds the pre-update value of the
    // stage before it, so the chain carries N-1 samples of extra latency
    // but no long adder chain. Overflow wraps by design.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) r_integ[k] <= '0;
        end else if (bus.in_valid) begin
            r_integ[0] <= r_integ[0] + w_din_ext;
            for (int k = 1; k < N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
        end
    end

    assign w_dec_hit = bus.in_valid && (r_dec_cnt == CNT_W'(R - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec_cnt <= '0;
            r_s_valid <= 1'b0;
        end else begin
            r_s_valid <= w_dec_hit;
            if (bus.in_valid) begin
                r_dec_cnt <= w_dec_hit ? '0 : r_dec_cnt + CNT_W'(1);
            end
        end
    end

    // The decimated sample is the last integrator as updated by the edge
    // that raised r_s_valid; it cannot change again before the combs latch
    // it, so no separate holding register is needed.
    assign w_c[0] = r_integ[N-1];

    for (genvar k = 1; k <= N; k++) begin : g_comb
        cic_comb_stage #(
            .M (M),
            .W (ACC_W)
        ) u_comb (
            .clk  (clk),
            .rst  (rst),
            .i_en (r_s_valid),
            .i_x  (w_c[k-1]),
            .o_y  (w_c[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s_valid;
            if (r_s_valid) r_dout <= w_c[N][ACC_W-1 -: OUT_W];
        end
    end

    assign bus.d_out     = r_dout;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench: two decimators (R=2,M=2 and R=4,M=1) share one input
// stream. The reference model treats the CIC as its equivalent FIR
// (box filter of length R*M convolved with itself N times), delayed by the
// N-1 samples of integrator pipelining, sampled every R-th valid input and
// scaled by 2^(N*log2(R*M)) with floor.
module tb_cic_decimator;
    import cic_decimator_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic signed [31:0] din;
    logic vin;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cic_decimator_if #(.IN_W(32), .OUT_W(32)) if_a ();
    cic_decimator_if #(.IN_W(32), .OUT_W(32)) if_b ();

    assign if_a.d_in     = din;
    assign if_a.in_valid = vin;
    assign if_b.d_in     = din;
    assign if_b.in_valid = vin;

    cic_decimator #(.R(2), .M(2), .N(4), .IN_W(32), .OUT_W(32)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave));
    cic_decimator #(.R(4), .M(1), .N(4), .IN_W(32), .OUT_W(32)) dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave));

    // observed pulses: value and cycle stamp
    logic signed [63:0] oa_v[$], ob_v[$];
    int                 oa_c[$], ob_c[$];
    // accepted input samples and the cycle each was presented in
    logic signed [63:0] xs[$];
    int                 xc[$];
    logic signed [63:0] dc_ref[$];

    always @(negedge clk) begin
        if (if_a.out_valid === 1'b1) begin oa_v.push_back(if_a.d_out); oa_c.push_back(cyc); end
        if (if_b.out_valid === 1'b1) begin ob_v.push_back(if_b.d_out); ob_c.push_back(cyc); end
    end

    // ---------------- reference model ----------------
    function automatic void model(input int r, input int m,
                                  output logic signed [63:0] ev[$], output int ec[$]);
        longint h[];
        longint t[];
        int     len;
        int     sh;
        len = r * m;
        sh  = 4 * clog2(len);
        h = new[1];
        h[0] = 1;
        for (int s = 0; s < 4; s++) begin
            t = new[h.size() + len - 1];
            foreach (t[i]) t[i] = 0;
            foreach (h[i]) for (int k = 0; k < len; k++) t[i+k] += h[i];
            h = t;
        end
        ev.delete();
        ec.delete();
        for (int n = r - 1; n < xs.size(); n += r) begin
            longint y;
            y = 0;
            foreach (h[k]) if (n - 3 - k >= 0) y += h[k] * longint'(xs[n-3-k]);
            ev.push_back(y >>> sh);
            ec.push_back(xc[n] + 2);
        end
    endfunction

    function automatic void fetch(input int s,
                                  output logic signed [63:0] ev[$], output int ec[$],
                                  output logic signed [63:0] ov[$], output int oc[$]);
        if (s == 0) begin model(2, 2, ev, ec); ov = oa_v; oc = oa_c; end
        else        begin model(4, 1, ev, ec); ov = ob_v; oc = ob_c; end
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic signed [31:0] d);
        din = d;
        vin = v;
        if (v) begin xs.push_back(d); xc.push_back(cyc); end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        xs.delete(); xc.delete();
        oa_v.delete(); oa_c.delete(); ob_v.delete(); ob_c.delete();
    endtask

    task automatic fresh();
        vin = 1'b0;
        din = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic flush();
        repeat (6) step(1'b0, 32'sd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        fresh();
        repeat (12) step(1'b1, 32'sd1000);
        checks++;
        if (if_a.d_out === 32'sd0) begin
            errors++; $display("FAIL reset_pre_nonzero: d_out=%0d want nonzero", if_a.d_out);
        end
        // drop reset mid-cycle while inputs are still streaming
        vin = 1'b1;
        #3 rst = 1'b0;
        #1;
        checks++;
        if (if_a.d_out !== 32'sd0 || if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async_a: d_out=%0d ov=%b want 0 0", if_a.d_out, if_a.out_valid);
        end
        checks++;
        if (if_b.d_out !== 32'sd0 || if_b.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async_b: d_out=%0d ov=%b want 0 0", if_b.d_out, if_b.out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_logs();
        repeat (8) step(1'b1, 32'sd1000);
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL reset_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL reset_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_dc();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        fresh();
        repeat (40) step(1'b1, 32'sd1000);
        flush();
        dc_ref = oa_v;
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL dc_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL dc_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
            checks++;
            if (ov.size() == 0 || ov[ov.size()-1] !== 64'sd1000) begin
                errors++; $display("FAIL dc_settle[%0d]: got %0d want 1000", s, ov.size() ? ov[ov.size()-1] : 0);
            end
        end
        // default config: settled by output 8 and stays there
        for (int i = 7; i < oa_v.size(); i++) begin
            checks++;
            if (oa_v[i] !== 64'sd1000) begin
                errors++; $display("FAIL dc_hold[%0d]: got %0d want 1000", i, oa_v[i]);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        longint sum;
        fresh();
        step(1'b1, 32'sd256);
        repeat (31) step(1'b1, 32'sd0);
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL imp_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL imp_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
        end
        // even-phase taps of (1+z^-1+z^-2+z^-3)^4: 1,10,31,44,31,10,1
        sum = 0;
        foreach (oa_v[i]) sum += oa_v[i];
        checks++;
        if (sum !== 128) begin
            errors++; $display("FAIL imp_sum: got %0d want 128", sum);
        end
        checks++;
        if (oa_v.size() < 5 || oa_v[4] !== 64'sd44) begin
            errors++; $display("FAIL imp_peak: got %0d want 44", oa_v.size() >= 5 ? oa_v[4] : 0);
        end
        checks++;
        if (oa_v.size() == 0 || oa_v[oa_v.size()-1] !== 64'sd0) begin
            errors++; $display("FAIL imp_tail: got %0d want 0", oa_v.size() ? oa_v[oa_v.size()-1] : 0);
        end
    endtask

    task automatic test_fullscale();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        fresh();
        repeat (40) step(1'b1, 32'sh8000_0000);
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL fs_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL fs_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
            checks++;
            if (ov.size() == 0 || ov[ov.size()-1] !== -64'sd2147483648) begin
                errors++; $display("FAIL fs_settle[%0d]: got %0d want -2147483648", s, ov.size() ? ov[ov.size()-1] : 0);
            end
        end
    endtask

    task automatic test_gapped();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        int n;
        fresh();
        n = 0;
        while (n < 40) begin
            if ($urandom_range(0, 1) == 1) begin step(1'b1, 32'sd1000); n++; end
            else step(1'b0, $urandom);
        end
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL gap_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL gap_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
        end
        checks++;
        if (oa_v.size() !== dc_ref.size()) begin
            errors++; $display("FAIL gap_vs_dc_len: got %0d want %0d", oa_v.size(), dc_ref.size());
        end
        for (int i = 0; i < oa_v.size() && i < dc_ref.size(); i++) begin
            checks++;
            if (oa_v[i] !== dc_ref[i]) begin
                errors++; $display("FAIL gap_vs_dc[%0d]: got %0d want %0d", i, oa_v[i], dc_ref[i]);
            end
        end
    endtask

    task automatic test_random();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        fresh();
        repeat (240) step($urandom_range(0, 3) != 0, $urandom);
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL rnd_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
        end
    endtask

    task automatic test_r4m1();
        logic signed [63:0] ev[$], ov[$];
        int ec[$], oc[$];
        fresh();
        repeat (48) step(1'b1, -32'sd500);
        flush();
        for (int s = 0; s < 2; s++) begin
            fetch(s, ev, ec, ov, oc);
            checks++;
            if (ov.size() !== ev.size()) begin
                errors++; $display("FAIL r4_count[%0d]: got %0d want %0d", s, ov.size(), ev.size());
            end
            for (int i = 0; i < ev.size() && i < ov.size(); i++) begin
                checks++;
                if (ov[i] !== ev[i] || oc[i] !== ec[i]) begin
                    errors++;
                    $display("FAIL r4_out[%0d][%0d]: got %0d@%0d want %0d@%0d", s, i, ov[i], oc[i], ev[i], ec[i]);
                end
            end
        end
        // R=4,M=1: gain 4^4 / 2^8 = 1, so DC passes unchanged
        checks++;
        if (ob_v.size() !== 12 || ob_v[ob_v.size()-1] !== -64'sd500) begin
            errors++;
            $display("FAIL r4_settle: got %0d outputs last %0d want 12 outputs last -500",
                     ob_v.size(), ob_v.size() ? ob_v[ob_v.size()-1] : 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        vin = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_dc();
        test_impulse();
        test_fullscale();
        test_gapped();
        test_random();
        test_r4m1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
